cover_toggle_collector: RTL and testbench

//  Receiving end of the toggle-coverage hit vector. Accumulates per-point

---
 rtl/cover_toggle_collector.sv | 95 +++++++++
 tb/tb_cover_toggle_collector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage collector: de-duplicates per-point hits and drains
// each first-time hit as an absolute cover index on a valid/ready stream.
module cover_toggle_collector #(
  parameter int unsigned     WIDTH       = 62,
  parameter longint unsigned COVER_INDEX = 0,
  localparam int unsigned    CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] hit,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_covered, r_pending;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_out_index;

  logic [WIDTH-1:0] w_newhit, w_take;
  logic [63:0]      w_low_idx;
  logic [CNT_W-1:0] w_pop;
  logic             w_latch;

  assign w_newhit = hit & ~r_covered;

  // Lowest set pending bit as both a one-hot mask and a bit position.
  always_comb begin
    w_take    = '0;
    w_low_idx = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (r_pending[i-1]) begin
        w_take    = '0;
        w_take[i-1] = 1'b1;
        w_low_idx = 64'(i - 1);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(w_newhit[i]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending != '0) begin
          w_latch      = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (r_pending != '0) w_latch = 1'b1;
          else                 w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      r_state     <= IDLE;
      r_covered   <= '0;
      r_pending   <= '0;
      r_count     <= '0;
      r_out_index <= '0;
    end else begin
      r_state   <= w_state_next;
      r_covered <= r_covered | hit;
      // Selection uses pre-merge pending, so a new hit waits at least one edge.
      r_pending <= (r_pending & ~(w_latch ? w_take : '0)) | w_newhit;
      r_count   <= r_count + w_pop;
      if (w_latch) r_out_index <= COVER_INDEX + w_low_idx;
    end
  end

  assign out_valid     = (r_state == SEND);
  assign out_index     = r_out_index;
  assign covered_count = r_count;
  assign all_covered   = (r_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed self-checking bench for cover_toggle_collector (WIDTH=62, base 100).
module tb_cover_toggle_collector;

  localparam int unsigned WIDTH = 62;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] hit;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  int n_cmp = 0;
  int n_bad = 0;

  cover_toggle_collector #(
    .WIDTH(WIDTH),
    .COVER_INDEX(64'd100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hit(hit),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .covered_count(covered_count),
    .all_covered(all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int nh;
    reset = 1'b0; clear = 1'b0; out_ready = 1'b0; hit = '1;
    @(negedge clock);

    // T1: reset held with all hits asserted
    step(); step();
    check("t1_valid_rst", 64'(out_valid), 64'd0);
    check("t1_count_rst", 64'(covered_count), 64'd0);
    check("t1_index_rst", out_index, 64'd0);
    check("t1_all_rst", 64'(all_covered), 64'd0);
    reset = 1'b1; hit = '0;
    step(); step();
    check("t1_valid_rel", 64'(out_valid), 64'd0);
    check("t1_count_rel", 64'(covered_count), 64'd0);
    check("t1_index_rel", out_index, 64'd0);

    // T2: single hit, one-cycle report, repeat ignored
    out_ready = 1'b1;
    hit = '0; hit[5] = 1'b1;
    step();
    hit = '0;
    check("t2_count", 64'(covered_count), 64'd1);
    check("t2_valid_early", 64'(out_valid), 64'd0);
    step();
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_index", out_index, 64'd105);
    step();
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    hit[5] = 1'b1;
    step();
    hit = '0;
    step();
    check("t2_rehit_valid", 64'(out_valid), 64'd0);
    check("t2_rehit_count", 64'(covered_count), 64'd1);

    // T3: 0b1011 drains as 100,101,103 back to back
    clear = 1'b1; step(); clear = 1'b0;
    check("t3_clear_count", 64'(covered_count), 64'd0);
    hit = '0; hit[3:0] = 4'b1011;
    step();
    hit = '0;
    check("t3_count", 64'(covered_count), 64'd3);
    step();
    check("t3_v0", 64'(out_valid), 64'd1);
    check("t3_i0", out_index, 64'd100);
    step();
    check("t3_v1", 64'(out_valid), 64'd1);
    check("t3_i1", out_index, 64'd101);
    step();
    check("t3_v2", 64'(out_valid), 64'd1);
    check("t3_i2", out_index, 64'd103);
    step();
    check("t3_idle", 64'(out_valid), 64'd0);

    // T4: backpressure holds the index stable
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b0;
    hit = '0; hit[0] = 1'b1; hit[7] = 1'b1;
    step();
    hit = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_index", out_index, 64'd100);
    end
    out_ready = 1'b1;
    step();
    check("t4_next_valid", 64'(out_valid), 64'd1);
    check("t4_next_index", out_index, 64'd107);
    step();
    check("t4_idle", 64'(out_valid), 64'd0);
    check("t4_count", 64'(covered_count), 64'd2);

    // T5: full coverage drains 100..161 in order
    clear = 1'b1; step(); clear = 1'b0;
    hit = '1;
    step();
    hit = '0;
    check("t5_count", 64'(covered_count), 64'd62);
    check("t5_all", 64'(all_covered), 64'd1);
    nh = 0;
    for (int c = 0; c < 100 && nh < 62; c++) begin
      if (out_valid) begin
        check("t5_index", out_index, 64'(100 + nh));
        nh++;
      end
      step();
    end
    check("t5_handshakes", 64'(nh), 64'd62);
    check("t5_idle", 64'(out_valid), 64'd0);

    // T6: clear mid-drain drops everything; rehit is reported again
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b0;
    hit = '0; hit[4:1] = 4'b1111;
    step();
    hit = '0;
    step();
    check("t6_send_valid", 64'(out_valid), 64'd1);
    check("t6_send_index", out_index, 64'd101);
    clear = 1'b1; step(); clear = 1'b0;
    check("t6_clr_valid", 64'(out_valid), 64'd0);
    check("t6_clr_count", 64'(covered_count), 64'd0);
    check("t6_clr_index", out_index, 64'd0);
    step();
    check("t6_no_stale", 64'(out_valid), 64'd0);
    hit[2] = 1'b1;
    step();
    hit = '0;
    step();
    check("t6_rehit_valid", 64'(out_valid), 64'd1);
    check("t6_rehit_index", out_index, 64'd102);
    check("t6_rehit_count", 64'(covered_count), 64'd1);
    out_ready = 1'b1;
    step();
    check("t6_end_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
